ex_stage_ctrl: RTL and testbench
================================

Name: ex_stage_ctrl

Overview:
- Sequencing controller for the EX stage ALU of the RV32IC pipeline.
- Per cycle it decides:
  - whether the EX instruction executes;
  - whether IF/ID stalls and ID/EX receives a bubble (load-use);
  - the redirect request after a taken branch or jump, and the drain of wrong-path instructions;
  - the operand forwarding selects for ALU inputs A and B.
- Replaces the ALU-local stalled-PC tracking with one explicit state machine.

Parameters:
- FLUSH_DEPTH, 2: cycles of ID/EX flush after a redirect; legal range 1..7.
- REDIRECT_TIMEOUT, 15: maximum cycles in WAIT_TGT before giving up; legal range 1..255.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ex_valid  in  1  valid instruction in EX.
- i_ex_pc  in  32  PC of the EX instruction.
- i_ex_rs1, i_ex_rs2  in  5 each  EX source registers.
- i_ex_rd  in  5  EX destination register.
- i_ex_memread  in  1  EX instruction is a load.
- i_id_valid  in  1  valid instruction in ID.
- i_id_rs1, i_id_rs2  in  5 each  ID source registers.
- i_mem_rd  in  5  MEM-stage destination register.
- i_mem_regwrite  in  1  MEM-stage register write enable.
- i_wb_rd  in  5  WB-stage destination register.
- i_wb_regwrite  in  1  WB-stage register write enable.
- i_resolve_valid  in  1  ALU resolution result valid this cycle.
- i_resolve_taken  in  1  conditional branch taken.
- i_resolve_jump  in  1  JAL or JALR.
- i_resolve_target  in  32  redirect target PC.
- o_ex_enable  out  1  EX instruction may execute and update MEM state.
- o_stall_if_id  out  1  hold PC and the IF/ID register.
- o_flush_id_ex  out  1  insert a bubble into ID/EX.
- o_redirect_valid  out  1  one-cycle redirect pulse to fetch.
- o_redirect_pc  out  32  redirect target.
- o_fwd_a, o_fwd_b  out  2 each  operand source: 00 register file, 01 MEM, 10 WB.
- o_timeout  out  1  sticky: redirect target never arrived.
- o_stall_cnt, o_flush_cnt  out  32 each  performance counters.

Behaviour:
- Reset (synchronous, i_reset=1 at a clock edge): the following take effect from the next cycle:
  - state=RUN; drain and timeout counters cleared; held target cleared;
  - o_redirect_valid=0, o_redirect_pc=0, o_timeout=0, counters=0.
- While i_reset=1, o_fwd_a/o_fwd_b are forced to 00 and o_ex_enable, o_stall_if_id, o_flush_id_ex are forced to 0.
- A reset mid-DRAIN or mid-WAIT_TGT abandons the redirect.
- Forwarding (combinational, every state), shown for A; B is identical using rs2:
  - 01 if i_mem_regwrite and i_mem_rd != 0 and i_mem_rd == i_ex_rs1;
  - otherwise 10 if i_wb_regwrite and i_wb_rd != 0 and i_wb_rd == i_ex_rs1;
  - otherwise 00.
  - MEM has priority over WB. x0 is never forwarded.
- State RUN:
  - o_ex_enable = i_ex_valid.
  - Load-use condition: i_ex_valid, i_ex_memread, i_ex_rd != 0, i_id_valid, and i_ex_rd equals i_id_rs1 or i_id_rs2. When it holds, o_stall_if_id=1 and o_flush_id_ex=1 combinationally for that cycle only; the load itself proceeds.
  - Take condition: i_resolve_valid and (i_resolve_taken or i_resolve_jump) in cycle N.
  - On take: in N+1, o_redirect_valid=1 for exactly one cycle, o_redirect_pc = target, target held internally, drain counter = FLUSH_DEPTH, state=DRAIN.
  - Take in the same cycle as load-use: the take is recorded; the load-use stall is still issued in cycle N (the bubble is harmless).
- State DRAIN:
  - o_flush_id_ex=1, o_ex_enable=0, o_stall_if_id=0.
  - Counter decrements each cycle; when it is 1 the next state is WAIT_TGT. DRAIN therefore lasts exactly FLUSH_DEPTH cycles.
  - i_resolve_valid is ignored (wrong-path instructions).
- State WAIT_TGT:
  - o_ex_enable=0 until i_ex_valid and i_ex_pc == held target.
  - On that match, o_ex_enable=1 in the same cycle and the next state is RUN.
  - A timeout counter increments each WAIT_TGT cycle. At REDIRECT_TIMEOUT with no match: o_timeout set (sticky until reset), next state RUN.
  - Resolutions are ignored; no load-use stall is issued.
- The timeout counter clears on entry to WAIT_TGT.
- The held target never changes outside the RUN-to-DRAIN transition.

Optional Feature:
- Macro EX_CTRL_PERF_EN.
- Defined:
  - o_stall_cnt increments each cycle with o_stall_if_id=1;
  - o_flush_cnt increments each cycle with o_flush_id_ex=1;
  - both wrap modulo 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic exists.

Decomposition:
- Package ex_ctrl_pkg holds:
  - ctrl_state_t enum: RUN, DRAIN, WAIT_TGT;
  - forwarding selects FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - ALUop constants ALUOP_BRANCH=1, ALUOP_JAL=6, ALUOP_JALR=7, for decode-side producers of i_resolve_jump.
- Sub-module ex_fwd_unit: purely combinational forwarding compare, instantiated once and producing both o_fwd_a and o_fwd_b.

Test Plan:
- Load-use: EX load with rd=5, ID add with rs1=5 -> o_stall_if_id=1 and o_flush_id_ex=1 for exactly one cycle; the next cycle both are 0; o_stall_cnt=1 with EX_CTRL_PERF_EN.
- Forwarding priority: mem_rd=wb_rd=ex_rs1=7, both regwrite=1 -> o_fwd_a=01. With rd=0 and a match on 0 -> 00.
- Taken branch: resolve_valid, taken=1, target=0x40 in cycle N:
  - N+1: o_redirect_valid=1, o_redirect_pc=0x40;
  - flush for 2 cycles (N+1, N+2);
  - i_ex_pc=0x40 with valid in N+5 -> o_ex_enable=1 in N+5; RUN in N+6.
- Timeout: redirect to 0x80 with no matching PC for 15 WAIT_TGT cycles -> o_timeout=1 and sticky; state RUN.
- Resolve during DRAIN: a second taken branch in N+2 -> no second redirect pulse; the target stays 0x40.
- Reset mid-WAIT_TGT: i_reset=1 for one cycle -> next cycle state RUN, o_redirect_pc=0, o_timeout=0, o_ex_enable follows i_ex_valid.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// ex_ctrl_pkg: shared types, forwarding selects and ALUop codes for the EX stage controller.
package ex_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, WAIT_TGT} ctrl_state_t;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [3:0] ALUOP_BRANCH = 4'd1;
  localparam logic [3:0] ALUOP_JAL    = 4'd6;
  localparam logic [3:0] ALUOP_JALR   = 4'd7;
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] mem_rd, input logic mem_we,
                                         input logic [4:0] wb_rd, input logic wb_we);
    return (mem_we && mem_rd != 5'd0 && mem_rd == rs) ? FWD_MEM :
           (wb_we && wb_rd != 5'd0 && wb_rd == rs) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/ex_stage_ctrl_fwd.sv
// ex_fwd_unit: combinational operand forwarding for ALU inputs A and B (MEM over WB, x0 never forwarded).
module ex_fwd_unit
  import ex_ctrl_pkg::*;
(
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_regwrite,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_regwrite,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b
);
  assign o_fwd_a = fwd_sel(i_ex_rs1, i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite);
  assign o_fwd_b = fwd_sel(i_ex_rs2, i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite);
endmodule

// File: rtl/ex_stage_ctrl.sv
// ex_stage_ctrl: EX stage sequencing (load-use stall, redirect/drain/target wait, forwarding).
// Optional performance counters enabled by defining EX_CTRL_PERF_EN.
module ex_stage_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH      = 2,
  parameter int REDIRECT_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ex_valid,
  input  logic [31:0] i_ex_pc,
  input  logic [4:0]  i_ex_rs1,
  input  logic [4:0]  i_ex_rs2,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_memread,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_regwrite,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_regwrite,
  input  logic        i_resolve_valid,
  input  logic        i_resolve_taken,
  input  logic        i_resolve_jump,
  input  logic [31:0] i_resolve_target,
  output logic        o_ex_enable,
  output logic        o_stall_if_id,
  output logic        o_flush_id_ex,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic [1:0]  o_fwd_a,
  output logic [1:0]  o_fwd_b,
  output logic        o_timeout,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);
  localparam logic [2:0] DRAIN_INIT = 3'(FLUSH_DEPTH);
  localparam logic [7:0] TMO_LAST   = 8'(REDIRECT_TIMEOUT - 1);
  ctrl_state_t r_state, w_next;
  logic [2:0]  r_drain;
  logic [7:0]  r_tmo;
  logic [31:0] r_target;
  logic        r_redirect_valid, r_timeout;
  logic [1:0]  w_fwd_a, w_fwd_b;
  logic        w_load_use, w_take, w_match, w_ex_en, w_stall, w_flush;
  ex_fwd_unit u_fwd (
    .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2),
    .i_mem_rd(i_mem_rd), .i_mem_regwrite(i_mem_regwrite),
    .i_wb_rd(i_wb_rd), .i_wb_regwrite(i_wb_regwrite),
    .o_fwd_a(w_fwd_a), .o_fwd_b(w_fwd_b)
  );
  assign w_load_use = i_ex_valid && i_ex_memread && i_ex_rd != 5'd0 && i_id_valid &&
                      (i_ex_rd == i_id_rs1 || i_ex_rd == i_id_rs2);
  assign w_take  = i_resolve_valid && (i_resolve_taken || i_resolve_jump);
  assign w_match = i_ex_valid && i_ex_pc == r_target;
  always_comb begin
    w_next  = r_state;
    w_ex_en = 1'b0;
    w_stall = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      RUN: begin
        w_ex_en = i_ex_valid;
        w_stall = w_load_use;
        w_flush = w_load_use;
        w_next  = w_take ? DRAIN : RUN;
      end
      DRAIN: begin
        w_flush = 1'b1;
        w_next  = (r_drain == 3'd1) ? WAIT_TGT : DRAIN;
      end
      WAIT_TGT: begin
        w_ex_en = w_match;
        w_next  = (w_match || r_tmo == TMO_LAST) ? RUN : WAIT_TGT;
      end
      default: w_next = RUN;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= RUN;
      r_drain          <= 3'd0;
      r_tmo            <= 8'd0;
      r_target         <= 32'd0;
      r_redirect_valid <= 1'b0;
      r_timeout        <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_redirect_valid <= r_state == RUN && w_take;
      if (r_state == RUN && w_take) begin
        r_target <= i_resolve_target;
        r_drain  <= DRAIN_INIT;
      end else if (r_state == DRAIN) begin
        r_drain <= r_drain - 3'd1;
      end
      // zero outside WAIT_TGT so each wait starts counting afresh
      r_tmo <= (r_state == WAIT_TGT) ? r_tmo + 8'd1 : 8'd0;
      if (r_state == WAIT_TGT && !w_match && r_tmo == TMO_LAST) r_timeout <= 1'b1;
    end
  end
  assign o_ex_enable      = !i_reset && w_ex_en;
  assign o_stall_if_id    = !i_reset && w_stall;
  assign o_flush_id_ex    = !i_reset && w_flush;
  assign o_fwd_a          = i_reset ? FWD_RF : w_fwd_a;
  assign o_fwd_b          = i_reset ? FWD_RF : w_fwd_b;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_target;
  assign o_timeout        = r_timeout;
`ifdef EX_CTRL_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {31'd0, o_stall_if_id};
      r_flush_cnt <= r_flush_cnt + {31'd0, o_flush_id_ex};
    end
  end
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_ex_stage_ctrl.sv
// tb_ex_stage_ctrl: table-driven RUN-state vectors plus directed redirect, timeout and reset sequences.
module tb_ex_stage_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ex_valid, ex_memread, id_valid, mem_rw, wb_rw, rv, rt, rj;
  logic [31:0] ex_pc, rtgt;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, id_rs1, id_rs2, mem_rd, wb_rd;
  logic        ex_en, stall, flush, redir, tmo;
  logic [31:0] redir_pc, stall_cnt, flush_cnt;
  logic [1:0]  fwd_a, fwd_b;
  int checks = 0, failures = 0;
  int m_stall = 0, m_flush = 0;
  always #5 clk = ~clk;
  ex_stage_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_ex_valid(ex_valid), .i_ex_pc(ex_pc),
    .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd), .i_ex_memread(ex_memread),
    .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_mem_rd(mem_rd), .i_mem_regwrite(mem_rw), .i_wb_rd(wb_rd), .i_wb_regwrite(wb_rw),
    .i_resolve_valid(rv), .i_resolve_taken(rt), .i_resolve_jump(rj), .i_resolve_target(rtgt),
    .o_ex_enable(ex_en), .o_stall_if_id(stall), .o_flush_id_ex(flush),
    .o_redirect_valid(redir), .o_redirect_pc(redir_pc), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
    .o_timeout(tmo), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );
  typedef struct packed {
    logic ex_valid, memread; logic [4:0] ex_rd, ex_rs1, ex_rs2;
    logic id_valid; logic [4:0] id_rs1, id_rs2, mem_rd; logic mem_rw; logic [4:0] wb_rd; logic wb_rw;
    logic e_en, e_st, e_fl; logic [1:0] e_fa, e_fb;
  } vec_t;
  vec_t vecs[11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // one call per non-reset cycle keeps the counter model aligned with the DUT
  task automatic chk_ctl(input string nm, input logic e_en, input logic e_st, input logic e_fl);
    chk({nm, "_en"}, {31'd0, ex_en}, {31'd0, e_en});
    chk({nm, "_stall"}, {31'd0, stall}, {31'd0, e_st});
    chk({nm, "_flush"}, {31'd0, flush}, {31'd0, e_fl});
    m_stall += int'(e_st);
    m_flush += int'(e_fl);
  endtask
  task automatic chk_cnt(input string nm);
`ifdef EX_CTRL_PERF_EN
    chk({nm, "_stall_cnt"}, stall_cnt, 32'(m_stall));
    chk({nm, "_flush_cnt"}, flush_cnt, 32'(m_flush));
`else
    chk({nm, "_stall_cnt"}, stall_cnt, 32'd0);
    chk({nm, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask
  task automatic idle();
    {ex_valid, ex_memread, id_valid, mem_rw, wb_rw, rv, rt, rj} = '0;
    {ex_rs1, ex_rs2, ex_rd, id_rs1, id_rs2, mem_rd, wb_rd} = '0;
    ex_pc = 32'h0; rtgt = 32'h0;
  endtask
  task automatic take(input logic [31:0] tgt, input logic jump);
    rv = 1'b1; rt = !jump; rj = jump; rtgt = tgt;
  endtask
  task automatic load_use_inputs();
    ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_valid = 1'b1; id_rs1 = 5'd5;
  endtask
  initial begin
    vecs[0]  = '{1'b1,1'b1,5'd5,5'd1,5'd2, 1'b1,5'd5,5'd6, 5'd0,1'b0,5'd0,1'b0, 1'b1,1'b1,1'b1,2'b00,2'b00};
    vecs[1]  = '{1'b1,1'b1,5'd5,5'd1,5'd2, 1'b1,5'd6,5'd5, 5'd0,1'b0,5'd0,1'b0, 1'b1,1'b1,1'b1,2'b00,2'b00};
    vecs[2]  = '{1'b1,1'b0,5'd5,5'd1,5'd2, 1'b1,5'd5,5'd6, 5'd0,1'b0,5'd0,1'b0, 1'b1,1'b0,1'b0,2'b00,2'b00};
    vecs[3]  = '{1'b1,1'b1,5'd0,5'd1,5'd2, 1'b1,5'd0,5'd0, 5'd0,1'b0,5'd0,1'b0, 1'b1,1'b0,1'b0,2'b00,2'b00};
    vecs[4]  = '{1'b1,1'b1,5'd5,5'd1,5'd2, 1'b0,5'd5,5'd6, 5'd0,1'b0,5'd0,1'b0, 1'b1,1'b0,1'b0,2'b00,2'b00};
    vecs[5]  = '{1'b0,1'b1,5'd5,5'd1,5'd2, 1'b1,5'd5,5'd6, 5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,2'b00};
    vecs[6]  = '{1'b1,1'b0,5'd8,5'd7,5'd3, 1'b0,5'd0,5'd0, 5'd7,1'b1,5'd7,1'b1, 1'b1,1'b0,1'b0,2'b01,2'b00};
    vecs[7]  = '{1'b1,1'b0,5'd8,5'd7,5'd7, 1'b0,5'd0,5'd0, 5'd7,1'b0,5'd7,1'b1, 1'b1,1'b0,1'b0,2'b10,2'b10};
    vecs[8]  = '{1'b1,1'b0,5'd8,5'd0,5'd0, 1'b0,5'd0,5'd0, 5'd0,1'b1,5'd0,1'b1, 1'b1,1'b0,1'b0,2'b00,2'b00};
    vecs[9]  = '{1'b1,1'b0,5'd8,5'd4,5'd9, 1'b0,5'd0,5'd0, 5'd9,1'b1,5'd4,1'b1, 1'b1,1'b0,1'b0,2'b10,2'b01};
    vecs[10] = '{1'b1,1'b0,5'd8,5'd4,5'd4, 1'b0,5'd0,5'd0, 5'd4,1'b0,5'd4,1'b0, 1'b1,1'b0,1'b0,2'b00,2'b00};
    idle();
    // outputs forced quiet while reset is asserted
    @(negedge clk);
    load_use_inputs(); ex_rs1 = 5'd7; mem_rd = 5'd7; mem_rw = 1'b1;
    #1;
    chk("rst_en", {31'd0, ex_en}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    @(negedge clk); reset = 1'b0; idle(); #1;
    chk("rst_redir", {31'd0, redir}, 32'd0);
    chk("rst_pc", redir_pc, 32'd0);
    chk("rst_tmo", {31'd0, tmo}, 32'd0);
    chk_cnt("rst");
    chk_ctl("rst_run", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      {ex_valid, ex_memread, ex_rd, ex_rs1, ex_rs2, id_valid, id_rs1, id_rs2, mem_rd, mem_rw, wb_rd, wb_rw} =
        {vecs[i].ex_valid, vecs[i].memread, vecs[i].ex_rd, vecs[i].ex_rs1, vecs[i].ex_rs2, vecs[i].id_valid,
         vecs[i].id_rs1, vecs[i].id_rs2, vecs[i].mem_rd, vecs[i].mem_rw, vecs[i].wb_rd, vecs[i].wb_rw};
      #1;
      chk_ctl($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_st, vecs[i].e_fl);
      chk($sformatf("vec%0d_fwd_a", i), {30'd0, fwd_a}, {30'd0, vecs[i].e_fa});
      chk($sformatf("vec%0d_fwd_b", i), {30'd0, fwd_b}, {30'd0, vecs[i].e_fb});
      if (i == 1) chk_cnt("vec1");
    end
    @(negedge clk); idle(); #1;
    chk_cnt("vecs_done");
    chk_ctl("idle", 1'b0, 1'b0, 1'b0);
    // taken branch to 0x40, second resolve during DRAIN ignored
    @(negedge clk); idle(); ex_valid = 1'b1; ex_pc = 32'h10; take(32'h40, 1'b0); #1;
    chk_ctl("brN", 1'b1, 1'b0, 1'b0);
    chk("brN_redir", {31'd0, redir}, 32'd0);
    @(negedge clk); idle(); ex_valid = 1'b1; ex_pc = 32'h14; #1;
    chk_ctl("brN1", 1'b0, 1'b0, 1'b1);
    chk("brN1_redir", {31'd0, redir}, 32'd1);
    chk("brN1_pc", redir_pc, 32'h40);
    @(negedge clk); idle(); ex_valid = 1'b1; ex_pc = 32'h18; take(32'h99, 1'b1); #1;
    chk_ctl("brN2", 1'b0, 1'b0, 1'b1);
    chk("brN2_redir", {31'd0, redir}, 32'd0);
    @(negedge clk); idle(); load_use_inputs(); ex_pc = 32'h44; #1;
    chk_ctl("brN3", 1'b0, 1'b0, 1'b0);
    chk("brN3_redir", {31'd0, redir}, 32'd0);
    chk("brN3_pc", redir_pc, 32'h40);
    @(negedge clk); idle(); ex_pc = 32'h40; #1;
    chk_ctl("brN4", 1'b0, 1'b0, 1'b0);
    @(negedge clk); idle(); ex_valid = 1'b1; ex_pc = 32'h40; #1;
    chk_ctl("brN5", 1'b1, 1'b0, 1'b0);
    @(negedge clk); idle(); load_use_inputs(); ex_pc = 32'h50; #1;
    chk_ctl("brN6", 1'b1, 1'b1, 1'b1);
    chk("brN6_pc", redir_pc, 32'h40);
    chk_cnt("br");
    // jump to 0x80 coinciding with a load-use, then no matching PC until timeout
    @(negedge clk); idle(); load_use_inputs(); ex_pc = 32'h60; take(32'h80, 1'b1); #1;
    chk_ctl("toN", 1'b1, 1'b1, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk); idle(); ex_valid = 1'b1; ex_pc = 32'h84; #1;
      chk_ctl($sformatf("to%0d", c), 1'b0, 1'b0, c <= 2);
      if (c == 1) chk("to_pc", redir_pc, 32'h80);
      if (c == 17) chk("to_not_yet", {31'd0, tmo}, 32'd0);
    end
    @(negedge clk); idle(); ex_valid = 1'b1; ex_pc = 32'h84; #1;
    chk_ctl("to18", 1'b1, 1'b0, 1'b0);
    chk("to18_tmo", {31'd0, tmo}, 32'd1);
    @(negedge clk); idle(); #1;
    chk_ctl("to19", 1'b0, 1'b0, 1'b0);
    chk("to19_sticky", {31'd0, tmo}, 32'd1);
    chk_cnt("to");
    // reset while waiting for target 0xC0
    @(negedge clk); idle(); take(32'hC0, 1'b0); #1;
    chk_ctl("rwN", 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); idle(); ex_valid = 1'b1; ex_pc = 32'h10; #1;
      chk_ctl($sformatf("rw%0d", c), 1'b0, 1'b0, c <= 2);
    end
    @(negedge clk); reset = 1'b1; ex_rs2 = 5'd3; wb_rd = 5'd3; wb_rw = 1'b1; #1;
    chk("rw_rst_en", {31'd0, ex_en}, 32'd0);
    chk("rw_rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    m_stall = 0; m_flush = 0;
    @(negedge clk); reset = 1'b0; idle(); ex_valid = 1'b1; ex_pc = 32'h10; #1;
    chk_ctl("rw_after", 1'b1, 1'b0, 1'b0);
    chk("rw_after_pc", redir_pc, 32'd0);
    chk("rw_after_tmo", {31'd0, tmo}, 32'd0);
    chk("rw_after_redir", {31'd0, redir}, 32'd0);
    chk_cnt("rw_after");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
